qa_drv_hc_write_arb: RTL and testbench
======================================

QA_DRV_HC_WRITE_ARB -- requirements
Module: qa_drv_hc_write_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, cache-line address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, cache-line data width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 64, limit on issued-but-unacknowledged writes (range 1..255).
REQ-004 SHALL use one clock and an asynchronous, active-low reset, named as below.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 req[1:0]  in  2  per-client write request; client 0 = status manager, client 1 = fifo-to-host writer.
REQ-008 req_fence[1:0]  in  2  per-client: request is a write fence (address and data ignored).
REQ-009 req_addr0, req_addr1  in  ADDR_WIDTH each  per-client line address.
REQ-010 req_data0, req_data1  in  DATA_WIDTH each  per-client line data.
REQ-011 grant[1:0]  out  1 each  combinational per-client grant (the writer's writerGrant).
REQ-012 can_issue  out  1  combinational: channel could accept a request this cycle.
REQ-013 tx_almost_full  in  1  host write channel back-pressure.
REQ-014 tx_valid  out  1  registered write issue to host channel.
REQ-015 tx_fence  out  1  registered: issued request is a fence.
REQ-016 tx_addr  out  ADDR_WIDTH  registered address; 0 for fences.
REQ-017 tx_data  out  DATA_WIDTH  registered data.
REQ-018 wr_rsp[1:0]  in  2  write-response strobes from the two host response ports, each one response.
REQ-019 outstanding  out  8  current in-flight count.
REQ-020 rsp_underflow  out  1  sticky error flag.

Function
REQ-021 can_issue SHALL equal !tx_almost_full && (outstanding < MAX_OUTSTANDING).
REQ-022 grant SHALL be one-hot or zero; no grant when can_issue is 0; a grant is asserted only to a client whose req is 1.
REQ-023 Arbitration SHALL be round-robin on a 1-bit priority register prio: the client equal to prio wins when both request; a lone requester wins regardless of prio.
REQ-024 After any grant to client k, prio SHALL become !k on the next edge; no grant leaves prio unchanged.
REQ-025 A granted client SHALL treat its request as consumed in the grant cycle; the block SHALL capture that client's fence, address and data in the same cycle.
REQ-026 tx_valid SHALL be 1 exactly in the cycle after a grant cycle (latency 1, no bubbles); back-to-back grants give back-to-back tx_valid.
REQ-027 When the granted request is a fence, tx_fence SHALL be 1, tx_addr 0; tx_data SHALL carry the captured value but is don't-care.
REQ-028 When tx_valid is 0, tx_fence SHALL be 0; tx_addr/tx_data hold their last value.
REQ-029 outstanding SHALL increment by 1 per grant (fences included) and decrement by popcount(wr_rsp); simultaneous grant and response(s) apply the net change in one cycle (+1, 0, -1).
REQ-030 A decrement that would take outstanding below 0 SHALL saturate at 0 and set rsp_underflow, which stays 1 until reset.
REQ-031 At outstanding == MAX_OUTSTANDING-1, a grant SHALL still be allowed; the next cycle can_issue is 0 unless a response arrives in that same grant cycle.
REQ-032 tx_almost_full asserted SHALL block grants in that same cycle; a request already captured is still issued the next cycle.

Reset
REQ-033 While reset_n is 0, regardless of clk: tx_valid=0, tx_fence=0, tx_addr=0, tx_data=0, outstanding=0, prio=0, rsp_underflow=0.
REQ-034 Reset asserted mid-operation SHALL discard a captured, not-yet-issued request; in-flight responses arriving after reset are counted as underflow.
REQ-035 grant SHALL be 0 while reset_n is 0.

Verification
REQ-036 Both clients request continuously, no back-pressure -> grants alternate 0,1,0,1...; tx_valid every cycle from cycle 2; tx_addr sequence follows with 1-cycle lag.
REQ-037 MAX_OUTSTANDING=4, no responses, client 1 requesting -> exactly 4 grants, can_issue=0, outstanding=4; one wr_rsp -> one more grant.
REQ-038 outstanding=3, grant plus wr_rsp=2'b11 in same cycle -> outstanding=2 next cycle.
REQ-039 Client 1 fence request with addr 0x1234 -> tx_valid=1, tx_fence=1, tx_addr=0 next cycle, outstanding +1.
REQ-040 tx_almost_full=1 for 5 cycles with both requesting -> no grants, tx_valid=0 after the pending issue; on release, prio-favoured client granted first.
REQ-041 wr_rsp=2'b01 at outstanding=0 -> outstanding stays 0, rsp_underflow=1 and held; async reset_n pulse mid-cycle clears it immediately.

Source files
------------

// File: rtl/qa_drv_hc_write_arb_if.sv
// Bundle of the two-client write request, host write channel and response signals
// seen by qa_drv_hc_write_arb; slave is the arbiter side, master the client/host side.
interface qa_drv_hc_write_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 512
);
    logic [1:0]            req;
    logic [1:0]            req_fence;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [DATA_WIDTH-1:0] req_data0;
    logic [DATA_WIDTH-1:0] req_data1;
    logic [1:0]            grant;
    logic                  can_issue;
    logic                  tx_almost_full;
    logic                  tx_valid;
    logic                  tx_fence;
    logic [ADDR_WIDTH-1:0] tx_addr;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [1:0]            wr_rsp;
    logic [7:0]            outstanding;
    logic                  rsp_underflow;

    modport slave (
        input  req, req_fence, req_addr0, req_addr1, req_data0, req_data1,
        input  tx_almost_full, wr_rsp,
        output grant, can_issue, tx_valid, tx_fence, tx_addr, tx_data,
        output outstanding, rsp_underflow
    );

    modport master (
        output req, req_fence, req_addr0, req_addr1, req_data0, req_data1,
        output tx_almost_full, wr_rsp,
        input  grant, can_issue, tx_valid, tx_fence, tx_addr, tx_data,
        input  outstanding, rsp_underflow
    );
endinterface

// File: rtl/qa_drv_hc_write_arb.sv
// Two-client round-robin write arbiter feeding the host write channel, with an
// in-flight write counter bounded by MAX_OUTSTANDING and a sticky response-underflow flag.
module qa_drv_hc_write_arb #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    qa_drv_hc_write_arb_if.slave   bus
);
    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

    // number of write responses reported in one cycle
    function automatic logic [1:0] rsp_count(input logic [1:0] rsp);
        rsp_count = {1'b0, rsp[0]} + {1'b0, rsp[1]};
    endfunction

    logic                  prio_r;
    logic                  tx_valid_r;
    logic                  tx_fence_r;
    logic [ADDR_WIDTH-1:0] tx_addr_r;
    logic [DATA_WIDTH-1:0] tx_data_r;
    logic [7:0]            outstanding_r;
    logic                  underflow_r;

    logic                  can_issue_s;
    logic [1:0]            grant_s;
    logic                  win_s;
    logic                  sel_fence_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [7:0]            inc_s;
    logic [7:0]            dec_s;
    logic [7:0]            outstanding_nxt_s;
    logic                  underflow_set_s;

    // arbitration: grant is suppressed during reset and whenever the channel cannot accept
    always_comb begin
        can_issue_s = !bus.tx_almost_full && (outstanding_r < MAX_OUT);
        grant_s     = 2'b00;
        win_s       = 1'b0;
        if (reset_n && can_issue_s) begin
            case (bus.req)
                2'b01: begin
                    grant_s = 2'b01;
                    win_s   = 1'b0;
                end
                2'b10: begin
                    grant_s = 2'b10;
                    win_s   = 1'b1;
                end
                2'b11: begin
                    grant_s = prio_r ? 2'b10 : 2'b01;
                    win_s   = prio_r;
                end
                default: begin
                    grant_s = 2'b00;
                    win_s   = 1'b0;
                end
            endcase
        end else begin
            grant_s = 2'b00;
            win_s   = 1'b0;
        end
    end

    // select the winning client's payload; fences carry a zero address
    always_comb begin
        sel_fence_s = 1'b0;
        sel_addr_s  = {ADDR_WIDTH{1'b0}};
        sel_data_s  = {DATA_WIDTH{1'b0}};
        if (win_s) begin
            sel_fence_s = bus.req_fence[1];
            sel_addr_s  = bus.req_addr1;
            sel_data_s  = bus.req_data1;
        end else begin
            sel_fence_s = bus.req_fence[0];
            sel_addr_s  = bus.req_addr0;
            sel_data_s  = bus.req_data0;
        end
        if (sel_fence_s) begin
            sel_addr_s = {ADDR_WIDTH{1'b0}};
        end else begin
            sel_addr_s = sel_addr_s;
        end
    end

    // net in-flight update; cannot wrap upward because a grant needs outstanding < MAX_OUT
    always_comb begin
        inc_s             = {7'd0, |grant_s};
        dec_s             = {6'd0, rsp_count(bus.wr_rsp)};
        outstanding_nxt_s = 8'd0;
        underflow_set_s   = 1'b0;
        if ((outstanding_r + inc_s) < dec_s) begin
            outstanding_nxt_s = 8'd0;
            underflow_set_s   = 1'b1;
        end else begin
            outstanding_nxt_s = outstanding_r + inc_s - dec_s;
            underflow_set_s   = 1'b0;
        end
    end

    // issue register: one cycle after each grant, address/data hold when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid_r <= 1'b0;
            tx_fence_r <= 1'b0;
            tx_addr_r  <= {ADDR_WIDTH{1'b0}};
            tx_data_r  <= {DATA_WIDTH{1'b0}};
        end else if (|grant_s) begin
            tx_valid_r <= 1'b1;
            tx_fence_r <= sel_fence_s;
            tx_addr_r  <= sel_addr_s;
            tx_data_r  <= sel_data_s;
        end else begin
            tx_valid_r <= 1'b0;
            tx_fence_r <= 1'b0;
        end
    end

    // round-robin pointer moves to the other client after every grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_r <= 1'b0;
        end else if (|grant_s) begin
            prio_r <= !win_s;
        end else begin
            prio_r <= prio_r;
        end
    end

    // in-flight counter and sticky underflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_r <= 8'd0;
            underflow_r   <= 1'b0;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            underflow_r   <= underflow_r | underflow_set_s;
        end
    end

    assign bus.grant         = grant_s;
    assign bus.can_issue     = can_issue_s;
    assign bus.tx_valid      = tx_valid_r;
    assign bus.tx_fence      = tx_fence_r;
    assign bus.tx_addr       = tx_addr_r;
    assign bus.tx_data       = tx_data_r;
    assign bus.outstanding   = outstanding_r;
    assign bus.rsp_underflow = underflow_r;
endmodule

// File: tb/tb_qa_drv_hc_write_arb.sv
// Bench for qa_drv_hc_write_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_qa_drv_hc_write_arb;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int MAX = 4;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    qa_drv_hc_write_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    qa_drv_hc_write_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // behavioural model state (what the block must hold after the last edge)
    int          m_out;
    int          m_prio;
    bit          m_uf;
    bit          m_valid;
    bit          m_fence;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    // model compare: check outputs at the falling edge, then advance the model
    always @(negedge clk) begin
        int win;
        int cnt;
        bit can;
        logic [1:0] eg;
        if (!reset_n) begin
            m_out = 0; m_prio = 0; m_uf = 0; m_valid = 0; m_fence = 0;
            m_addr = '0; m_data = '0;
        end
        can = !bus.tx_almost_full && (m_out < MAX);
        win = -1;
        if (reset_n && can) begin
            if (bus.req == 2'b11)      win = m_prio;
            else if (bus.req == 2'b01) win = 0;
            else if (bus.req == 2'b10) win = 1;
        end
        eg = (win < 0) ? 2'b00 : ((win == 1) ? 2'b10 : 2'b01);
        chk("grant", 64'(bus.grant), 64'(eg));
        chk("can_issue", 64'(bus.can_issue), 64'(can));
        chk("tx_valid", 64'(bus.tx_valid), 64'(m_valid));
        chk("tx_fence", 64'(bus.tx_fence), 64'(m_fence));
        chk("tx_addr", 64'(bus.tx_addr), 64'(m_addr));
        if (m_valid && !m_fence) chk("tx_data", 64'(bus.tx_data), 64'(m_data));
        chk("outstanding", 64'(bus.outstanding), 64'(m_out));
        chk("rsp_underflow", 64'(bus.rsp_underflow), 64'(m_uf));
        if (reset_n) begin
            if (win >= 0) begin
                m_valid = 1'b1;
                m_fence = bus.req_fence[win];
                m_addr  = m_fence ? '0 : ((win == 1) ? bus.req_addr1 : bus.req_addr0);
                m_data  = (win == 1) ? bus.req_data1 : bus.req_data0;
                m_prio  = 1 - win;
            end else begin
                m_valid = 1'b0;
                m_fence = 1'b0;
            end
            cnt = m_out + ((win >= 0) ? 1 : 0) - (int'(bus.wr_rsp[0]) + int'(bus.wr_rsp[1]));
            if (cnt < 0) begin
                m_out = 0;
                m_uf  = 1'b1;
            end else begin
                m_out = cnt;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.req = 2'b00; bus.req_fence = 2'b00;
        bus.req_addr0 = '0; bus.req_addr1 = '0;
        bus.req_data0 = '0; bus.req_data1 = '0;
        bus.tx_almost_full = 1'b0; bus.wr_rsp = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_underflow", 64'(bus.rsp_underflow), 64'd0);
        chk("rst_can_issue", 64'(bus.can_issue), 64'd1);
        step();

        // client 1 fence with a non-zero address
        bus.req = 2'b10; bus.req_fence = 2'b10; bus.req_addr1 = 32'h0000_1234;
        @(negedge clk);
        chk("fence_grant", 64'(bus.grant), 64'h2);
        step();
        bus.req = 2'b00; bus.req_fence = 2'b00;
        bus.wr_rsp = 2'b01;
        @(negedge clk);
        chk("fence_tx_valid", 64'(bus.tx_valid), 64'd1);
        chk("fence_tx_fence", 64'(bus.tx_fence), 64'd1);
        chk("fence_tx_addr", 64'(bus.tx_addr), 64'd0);
        chk("fence_outstanding", 64'(bus.outstanding), 64'd1);
        step();
        bus.wr_rsp = 2'b00;

        // outstanding limit with client 1 requesting and no responses
        bus.req = 2'b10; bus.req_addr1 = 32'h0000_0100;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.grant[1]) n++;
            step();
        end
        chk("limit_grants", 64'(n), 64'd4);
        bus.wr_rsp = 2'b01;
        @(negedge clk);
        chk("limit_outstanding", 64'(bus.outstanding), 64'd4);
        chk("limit_can_issue", 64'(bus.can_issue), 64'd0);
        step();
        bus.wr_rsp = 2'b00;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.grant[1]) n++;
            step();
        end
        chk("limit_one_more", 64'(n), 64'd1);

        // grant and two responses in one cycle at outstanding 3
        bus.req = 2'b00; bus.wr_rsp = 2'b01;
        step();
        bus.req = 2'b01; bus.wr_rsp = 2'b11;
        @(negedge clk);
        chk("net_pre_outstanding", 64'(bus.outstanding), 64'd3);
        chk("net_grant", 64'(bus.grant), 64'h1);
        step();
        bus.req = 2'b00; bus.wr_rsp = 2'b00;
        @(negedge clk);
        chk("net_outstanding", 64'(bus.outstanding), 64'd2);

        // both clients continuously, responses keep the count flowing
        bus.wr_rsp = 2'b11;
        step();
        bus.req = 2'b11; bus.req_addr0 = 32'h0000_00A0; bus.req_addr1 = 32'h0000_00B1;
        for (int i = 0; i < 8; i++) begin
            bus.wr_rsp = (i > 0) ? 2'b01 : 2'b00;
            @(negedge clk);
            chk("rr_grant", 64'(bus.grant), (i % 2 == 0) ? 64'h2 : 64'h1);
            if (i > 0) begin
                chk("rr_tx_valid", 64'(bus.tx_valid), 64'd1);
                chk("rr_tx_addr", 64'(bus.tx_addr), (i % 2 == 1) ? 64'hB1 : 64'hA0);
            end
            step();
        end
        bus.req = 2'b00; bus.wr_rsp = 2'b01;
        step();
        bus.wr_rsp = 2'b00;

        // back-pressure blocks grants; priority client goes first on release
        bus.req = 2'b11; bus.tx_almost_full = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.grant != 2'b00) n++;
            chk("af_tx_valid", 64'(bus.tx_valid), 64'd0);
            step();
        end
        chk("af_grants", 64'(n), 64'd0);
        bus.tx_almost_full = 1'b0;
        @(negedge clk);
        chk("af_release_grant", 64'(bus.grant), 64'h2);
        step();
        bus.req = 2'b00; bus.wr_rsp = 2'b01;
        step();
        bus.wr_rsp = 2'b00;

        // response with nothing in flight, then async reset clears the flag
        bus.wr_rsp = 2'b01;
        step();
        bus.wr_rsp = 2'b00;
        @(negedge clk);
        chk("uf_outstanding", 64'(bus.outstanding), 64'd0);
        chk("uf_flag", 64'(bus.rsp_underflow), 64'd1);
        step();
        step();
        @(negedge clk);
        chk("uf_sticky", 64'(bus.rsp_underflow), 64'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("uf_async_clear", 64'(bus.rsp_underflow), 64'd0);
        chk("uf_async_out", 64'(bus.outstanding), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // randomized traffic with occasional mid-run reset
        for (int i = 0; i < 3000; i++) begin
            bus.req            = 2'($urandom_range(0, 3));
            bus.req_fence      = {($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0)};
            bus.req_addr0      = $urandom();
            bus.req_addr1      = $urandom();
            bus.req_data0      = {$urandom(), $urandom()};
            bus.req_data1      = {$urandom(), $urandom()};
            bus.tx_almost_full = ($urandom_range(0, 4) == 0);
            bus.wr_rsp         = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            reset_n            = ($urandom_range(0, 399) != 0);
            step();
        end
        reset_n = 1'b1;
        bus.req = 2'b00; bus.wr_rsp = 2'b00; bus.tx_almost_full = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
